// File: rtl/fifo_skew_sched.sv
// fifo_skew_sched: sequences ROWS row FIFOs into the array's west edge.
// Row i pops for len_q advancing cycles starting i cycles after row 0,
// giving the diagonal input skew. Any due-but-empty FIFO freezes the whole
// schedule so the skew between rows is preserved.
module fifo_skew_sched #(
  parameter int unsigned ROWS = 4,
  parameter int unsigned SIZE = 16
) (
  input  logic                  clk,
  input  logic                  nRST,
  input  logic                  start,
  input  logic [$clog2(SIZE):0] len,
  input  logic                  abort,
  input  logic [ROWS-1:0]       fifo_empty,
  output logic [ROWS-1:0]       pop,
  output logic                  array_en,
  output logic                  stall,
  output logic                  busy,
  output logic                  done
);

  localparam int unsigned LW = $clog2(SIZE) + 1;
  localparam int unsigned CW = $clog2(SIZE + ROWS) + 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   t_q, t_d;
  logic [LW-1:0]   len_q, len_d;
  logic [ROWS-1:0] due;
  logic [CW-1:0]   t_last;

  // Row i is due while i <= t < i+len_q; CW is wide enough that no sum wraps.
  always_comb begin
    due = '0;
    for (int unsigned i = 0; i < ROWS; i++) begin
      due[i] = (t_q >= CW'(i)) && (t_q < (CW'(i) + CW'(len_q)));
    end
  end

  // Final schedule step; len_q >= 1 in RUN so this never goes negative.
  always_comb begin
    t_last = CW'(len_q) + CW'(ROWS) - CW'(2);
  end

  // Pop/advance strobes decoded combinationally from registered state.
  always_comb begin
    stall    = 1'b0;
    array_en = 1'b0;
    pop      = '0;
    if ((state_q == RUN) && !abort) begin
      stall    = |(due & fifo_empty);
      array_en = !stall;
      pop      = stall ? '0 : due;
    end
  end

  // Status flags come straight from the state register.
  always_comb begin
    busy = (state_q == RUN);
    done = (state_q == DONE);
  end

  // Next-state and schedule-counter update.
  always_comb begin
    state_d = state_q;
    t_d     = t_q;
    len_d   = len_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          len_d   = len;
          t_d     = '0;
          state_d = (len == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        if (abort) begin
          state_d = IDLE;
          t_d     = '0;
        end else if (!stall) begin
          if (t_q == t_last) begin
            state_d = DONE;
            t_d     = '0;
          end else begin
            t_d = t_q + CW'(1);
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      state_q <= IDLE;
      t_q     <= '0;
      len_q   <= '0;
    end else begin
      state_q <= state_d;
      t_q     <= t_d;
      len_q   <= len_d;
    end
  end

endmodule

// File: tb/tb_fifo_skew_sched.sv
// tb_fifo_skew_sched: scoreboard bench; per-cycle expected output vectors
// {busy, done, stall, array_en, pop} are queued alongside their stimulus.
module tb_fifo_skew_sched;

  localparam int unsigned ROWS = 4;
  localparam int unsigned SIZE = 16;
  localparam int unsigned LW   = $clog2(SIZE) + 1;
  localparam int unsigned VW   = ROWS + 4;

  localparam logic [VW-1:0] IDLE_V  = '0;
  localparam logic [VW-1:0] DONE_V  = {4'b0100, {ROWS{1'b0}}};
  localparam logic [VW-1:0] STALL_V = {4'b1010, {ROWS{1'b0}}};
  localparam logic [VW-1:0] ABORT_V = {4'b1000, {ROWS{1'b0}}};

  typedef struct packed {
    logic            start;
    logic [LW-1:0]   len;
    logic            abort;
    logic [ROWS-1:0] emp;
  } stim_t;

  logic            clk = 1'b0;
  logic            nRST;
  logic            start;
  logic [LW-1:0]   len;
  logic            abort;
  logic [ROWS-1:0] fifo_empty;
  logic [ROWS-1:0] pop;
  logic            array_en;
  logic            stall;
  logic            busy;
  logic            done;

  int n_checks = 0;
  int n_fail   = 0;

  stim_t         stim_q[$];
  logic [VW-1:0] exp_q[$];

  fifo_skew_sched #(.ROWS(ROWS), .SIZE(SIZE)) dut (
    .clk        (clk),
    .nRST       (nRST),
    .start      (start),
    .len        (len),
    .abort      (abort),
    .fifo_empty (fifo_empty),
    .pop        (pop),
    .array_en   (array_en),
    .stall      (stall),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  // Expected RUN-cycle vector at schedule step t for length l.
  function automatic logic [VW-1:0] run_vec(input int t, input int l);
    logic [ROWS-1:0] p;
    p = '0;
    for (int i = 0; i < ROWS; i++) p[i] = (t >= i) && (t < i + l);
    return {4'b1001, p};
  endfunction

  function automatic logic [VW-1:0] obs_vec();
    return {busy, done, stall, array_en, pop};
  endfunction

  function automatic stim_t mk(input logic st, input int l, input logic ab,
                               input logic [ROWS-1:0] emp);
    stim_t s;
    s.start = st;
    s.len   = LW'(l);
    s.abort = ab;
    s.emp   = emp;
    return s;
  endfunction

  task automatic push(input stim_t s, input logic [VW-1:0] e);
    stim_q.push_back(s);
    exp_q.push_back(e);
  endtask

  // Inputs are applied at posedge+1; outputs are sampled at posedge+2.
  task automatic drive(input stim_t s);
    start      = s.start;
    len        = s.len;
    abort      = s.abort;
    fifo_empty = s.emp;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Uninterrupted schedule: IDLE(start) -> RUN x (l+ROWS-1) -> DONE.
  task automatic queue_schedule(input int l, input logic start_held);
    push(mk(1'b1, l, 1'b0, '0), IDLE_V);
    if (l > 0) begin
      for (int t = 0; t < l + int'(ROWS) - 1; t++)
        push(mk(start_held, l, 1'b0, '0), run_vec(t, l));
    end
    push(mk(start_held, l, 1'b0, '0), DONE_V);
  endtask

  task automatic test_reset();
    nRST = 1'b0; start = 1'b1; len = LW'(3); abort = 1'b0; fifo_empty = '0;
    for (int k = 0; k < 2; k++) begin
      @(posedge clk);
      #2;
      n_checks++;
      if (obs_vec() !== IDLE_V) begin
        n_fail++;
        $display("FAIL reset_hold k=%0d: got %b want %b", k, obs_vec(), IDLE_V);
      end
    end
    @(posedge clk);
    #1;
    nRST = 1'b1; start = 1'b0;
    #1;
    n_checks++;
    if (obs_vec() !== IDLE_V) begin
      n_fail++;
      $display("FAIL reset_release: got %b want %b", obs_vec(), IDLE_V);
    end
    tick();
  endtask

  task automatic test_basic();
    int cnt[ROWS];
    int k;
    logic [VW-1:0] e, o;
    foreach (cnt[i]) cnt[i] = 0;
    k = 0;
    queue_schedule(3, 1'b0);
    push(mk(1'b0, 3, 1'b0, '0), IDLE_V);
    while (exp_q.size() > 0) begin
      drive(stim_q.pop_front());
      e = exp_q.pop_front();
      o = obs_vec();
      n_checks++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL basic k=%0d: got %b want %b", k, o, e);
      end
      for (int i = 0; i < ROWS; i++) if (pop[i]) cnt[i]++;
      k++;
      tick();
    end
    for (int i = 0; i < ROWS; i++) begin
      n_checks++;
      if (cnt[i] != 3) begin
        n_fail++;
        $display("FAIL basic_pops row%0d: got %0d want 3", i, cnt[i]);
      end
    end
  endtask

  task automatic test_stall();
    int cnt[ROWS];
    int k;
    logic [VW-1:0] e, o;
    foreach (cnt[i]) cnt[i] = 0;
    k = 0;
    push(mk(1'b1, 3, 1'b0, '0), IDLE_V);
    // Row 3 empty at t=0 is not due, so no stall.
    push(mk(1'b0, 3, 1'b0, 4'b1000), run_vec(0, 3));
    push(mk(1'b0, 3, 1'b0, '0), run_vec(1, 3));
    push(mk(1'b0, 3, 1'b0, '0), run_vec(2, 3));
    push(mk(1'b0, 3, 1'b0, 4'b0100), STALL_V);
    push(mk(1'b0, 3, 1'b0, 4'b0100), STALL_V);
    for (int t = 3; t <= 5; t++) push(mk(1'b0, 3, 1'b0, '0), run_vec(t, 3));
    push(mk(1'b0, 3, 1'b0, '0), DONE_V);
    push(mk(1'b0, 3, 1'b0, '0), IDLE_V);
    while (exp_q.size() > 0) begin
      drive(stim_q.pop_front());
      e = exp_q.pop_front();
      o = obs_vec();
      n_checks++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL stall k=%0d: got %b want %b", k, o, e);
      end
      n_checks++;
      if ((pop & fifo_empty) !== '0) begin
        n_fail++;
        $display("FAIL stall_pop_empty k=%0d: got %b want 0000", k, pop & fifo_empty);
      end
      for (int i = 0; i < ROWS; i++) if (pop[i]) cnt[i]++;
      k++;
      tick();
    end
    for (int i = 0; i < ROWS; i++) begin
      n_checks++;
      if (cnt[i] != 3) begin
        n_fail++;
        $display("FAIL stall_pops row%0d: got %0d want 3", i, cnt[i]);
      end
    end
  endtask

  task automatic test_len0();
    int k;
    logic [VW-1:0] e, o;
    k = 0;
    queue_schedule(0, 1'b0);
    push(mk(1'b0, 0, 1'b0, '0), IDLE_V);
    while (exp_q.size() > 0) begin
      drive(stim_q.pop_front());
      e = exp_q.pop_front();
      o = obs_vec();
      n_checks++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL len0 k=%0d: got %b want %b", k, o, e);
      end
      k++;
      tick();
    end
  endtask

  task automatic test_len_max();
    int cnt[ROWS];
    int k;
    logic [VW-1:0] e, o;
    foreach (cnt[i]) cnt[i] = 0;
    k = 0;
    queue_schedule(int'(SIZE), 1'b0);
    push(mk(1'b0, int'(SIZE), 1'b0, '0), IDLE_V);
    while (exp_q.size() > 0) begin
      drive(stim_q.pop_front());
      e = exp_q.pop_front();
      o = obs_vec();
      n_checks++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL len_max k=%0d: got %b want %b", k, o, e);
      end
      for (int i = 0; i < ROWS; i++) if (pop[i]) cnt[i]++;
      k++;
      tick();
    end
    for (int i = 0; i < ROWS; i++) begin
      n_checks++;
      if (cnt[i] != int'(SIZE)) begin
        n_fail++;
        $display("FAIL len_max_pops row%0d: got %0d want %0d", i, cnt[i], SIZE);
      end
    end
  endtask

  task automatic test_midrun();
    int k;
    logic [VW-1:0] e, o;
    // start re-asserted at t=1 is ignored; abort at t=2 ends without done.
    k = 0;
    push(mk(1'b1, 5, 1'b0, '0), IDLE_V);
    push(mk(1'b0, 5, 1'b0, '0), run_vec(0, 5));
    push(mk(1'b1, 5, 1'b0, '0), run_vec(1, 5));
    push(mk(1'b0, 5, 1'b1, '0), ABORT_V);
    push(mk(1'b0, 5, 1'b0, '0), IDLE_V);
    push(mk(1'b0, 5, 1'b0, '0), IDLE_V);
    // Fresh schedule to be interrupted by reset at t=4.
    push(mk(1'b1, 5, 1'b0, '0), IDLE_V);
    for (int t = 0; t <= 3; t++) push(mk(1'b0, 5, 1'b0, '0), run_vec(t, 5));
    while (exp_q.size() > 0) begin
      drive(stim_q.pop_front());
      e = exp_q.pop_front();
      o = obs_vec();
      n_checks++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL midrun k=%0d: got %b want %b", k, o, e);
      end
      k++;
      tick();
    end
    drive(mk(1'b0, 5, 1'b0, '0));
    n_checks++;
    if (obs_vec() !== run_vec(4, 5)) begin
      n_fail++;
      $display("FAIL midrun_t4: got %b want %b", obs_vec(), run_vec(4, 5));
    end
    #2;
    nRST = 1'b0;
    #1;
    n_checks++;
    if (obs_vec() !== IDLE_V) begin
      n_fail++;
      $display("FAIL async_reset: got %b want %b", obs_vec(), IDLE_V);
    end
    @(posedge clk);
    #1;
    n_checks++;
    if (obs_vec() !== IDLE_V) begin
      n_fail++;
      $display("FAIL reset_edge: got %b want %b", obs_vec(), IDLE_V);
    end
    nRST = 1'b1;
    tick();
    drive(mk(1'b1, 1, 1'b0, '0));
    n_checks++;
    if (obs_vec() !== IDLE_V) begin
      n_fail++;
      $display("FAIL post_reset_idle: got %b want %b", obs_vec(), IDLE_V);
    end
    tick();
    drive(mk(1'b0, 1, 1'b0, '0));
    n_checks++;
    if (obs_vec() !== run_vec(0, 1)) begin
      n_fail++;
      $display("FAIL post_reset_run: got %b want %b", obs_vec(), run_vec(0, 1));
    end
    tick();
    drive(mk(1'b0, 1, 1'b1, '0));
    tick();
    drive(mk(1'b0, 1, 1'b0, '0));
    tick();
  endtask

  task automatic test_back_to_back();
    int k;
    logic [VW-1:0] e, o;
    k = 0;
    queue_schedule(2, 1'b1);
    queue_schedule(2, 1'b1);
    push(mk(1'b0, 2, 1'b0, '0), IDLE_V);
    while (exp_q.size() > 0) begin
      drive(stim_q.pop_front());
      e = exp_q.pop_front();
      o = obs_vec();
      n_checks++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL back_to_back k=%0d: got %b want %b", k, o, e);
      end
      k++;
      tick();
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    nRST = 1'b0; start = 1'b0; len = '0; abort = 1'b0; fifo_empty = '0;
    test_reset();
    test_basic();
    test_stall();
    test_len0();
    test_len_max();
    test_midrun();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fifo_skew_sched.md
Name: fifo_skew_sched

Overview:
Controller that sequences a bank of ROWS input FIFOs feeding the west edge of the DSP systolic array. On a start command it pops each row FIFO for LEN consecutive advancing cycles, with row i delayed by i cycles, which produces the diagonal input skew the array needs. A global stall freezes the whole schedule whenever any FIFO that is due to pop is empty, so skew alignment is never lost. The block issues pops and an array-advance enable only; FIFO data goes straight from the FIFOs to the array.

Parameters:
ROWS, 4, number of row FIFOs / array rows (>=1)
SIZE, 16, depth of each row FIFO; LEN width is $clog2(SIZE)+1
CW, $clog2(SIZE+ROWS)+1, internal schedule counter width (derived, not overridden)

Ports:
clk  input  1  system clock, rising edge
nRST  input  1  asynchronous reset, active low
start  input  1  begin a schedule; sampled only in IDLE
len  input  $clog2(SIZE)+1  elements per row, 0..SIZE; captured when start is accepted
abort  input  1  cancel the running schedule
fifo_empty  input  ROWS  is_empty of each row FIFO; bit i is row i
pop  output  ROWS  pop strobe to each row FIFO
array_en  output  1  array advances this cycle
stall  output  1  schedule is frozen this cycle because a due FIFO is empty
busy  output  1  state is RUN
done  output  1  one-cycle completion pulse

Behaviour:
- Reset, asynchronous, nRST=0: state=IDLE, t=0, len_q=0. pop, array_en, stall, busy and done are all 0. The same values hold for the whole time reset is asserted, including when reset hits in the middle of RUN. No partial pops after reset.
- States: IDLE, RUN, DONE.
- IDLE:
  - All outputs are 0.
  - start=1 at a rising edge: len_q<=len, t<=0.
  - If len==0, next state is DONE with no RUN cycles. Otherwise next state is RUN.
- RUN:
  - busy=1.
  - due[i]=1 when i <= t < i+len_q. The comparison uses CW-bit unsigned arithmetic with no overflow; max t = SIZE+ROWS-2.
  - stall = |(due & fifo_empty).
  - pop[i] = due[i] & ~stall. This is combinational from registered state, so there is zero latency. FIFO dat_out is valid in the same cycle as pop.
  - array_en = ~stall.
  - If not stalled: when t == len_q+ROWS-2, next state is DONE and t<=0; otherwise t<=t+1.
  - If stalled: t holds and no pop is issued on any row, including rows whose FIFO is not empty.
  - Cycles where no row is due still assert array_en=1. For example, t in the tail after row 0 has finished while later rows drain.
- DONE: done=1 for exactly one cycle, busy=0, pop=0. Next state is IDLE.
- abort=1 in RUN: pop, array_en and stall are forced to 0 that cycle. Next state is IDLE and t<=0. done is not pulsed.
- abort in IDLE or DONE is ignored. abort has priority over the end-of-schedule transition.
- start during RUN or DONE is ignored and not queued.
- pop is never asserted to an empty FIFO.
- Total pops per row per completed schedule equals len_q exactly.
- Non-stalled RUN cycles = len_q+ROWS-1.

Test Plan:
- ROWS=4, len=3, all fifo_empty=0, start pulsed at edge 0:
  - pop[0] in RUN cycles t=0..2; pop[1] at t=1..3; pop[2] at t=2..4; pop[3] at t=3..5.
  - array_en=1 for 6 cycles, then done=1 for one cycle, then IDLE.
- Same setup, but fifo_empty[2]=1 during t=3 for 2 cycles:
  - stall=1, pop=0000 and array_en=0 for 2 cycles, with t frozen at 3.
  - The schedule then resumes; done arrives 2 cycles later than in the first scenario; per-row pop count is still 3.
- len=0 with start:
  - IDLE, then DONE with done=1 for one cycle, then IDLE.
  - pop never asserted, busy never 1.
- len=SIZE=16, ROWS=4, no empties:
  - 19 non-stalled cycles; t reaches 18 without wrap.
  - pop[3] is high at t=3..18; done follows.
- Mid-run events, len=5, ROWS=4:
  - start reasserted during RUN: ignored.
  - abort at t=2: pop=0000 that cycle, then IDLE, no done pulse.
  - nRST dropped asynchronously at t=4: all outputs go to 0 immediately, and the block is in IDLE after release.
- Back-to-back schedules: start held high continuously.
  - The next schedule begins on the first IDLE cycle after DONE.
  - Exactly one idle gap cycle separates the two RUN periods.
